// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the RV32 integer register file.
package reg_file_pkg;

  localparam int NUM_REGISTERS_DEF = 32;
  localparam int DATA_WIDTH_DEF    = 32;
  localparam int ZERO_REG          = 0;

  // Address width needed to index n registers (at least one bit).
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: zero-register detect, range check and,
// when REGFILE_BYPASS_EN is defined, write-first forwarding from the
// write port.
module regfile_read_port
  import reg_file_pkg::*;
#(
  parameter int NUM_REGISTERS = NUM_REGISTERS_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int AW            = addr_width(NUM_REGISTERS)
) (
  input  logic [NUM_REGISTERS-1:1][DATA_WIDTH-1:0] regs_i,
  input  logic [AW-1:0]                            ra_i,
`ifdef REGFILE_BYPASS_EN
  input  logic                                     fwd_we_i,
  input  logic [AW-1:0]                            fwd_wa_i,
  input  logic [DATA_WIDTH-1:0]                    fwd_wd_i,
`endif
  output logic [DATA_WIDTH-1:0]                    rd_o
);

  logic ra_zero;
  logic ra_in_range;

  assign ra_zero     = (ra_i == AW'(ZERO_REG));
  assign ra_in_range = (int'(ra_i) < NUM_REGISTERS);

  // Select the addressed entry; zero and out-of-range addresses read as 0.
  always_comb begin
    rd_o = '0;
    if (!ra_zero && ra_in_range) begin
      for (int i = 1; i < NUM_REGISTERS; i++) begin
        if (ra_i == AW'(i)) rd_o = regs_i[i];
      end
`ifdef REGFILE_BYPASS_EN
      // ra is already known non-zero and in range, so a match implies a
      // legal write target; register 0 can never be forwarded.
      if (fwd_we_i && (fwd_wa_i == ra_i)) rd_o = fwd_wd_i;
`endif
    end
  end

endmodule

// File: rtl/reg_file.sv
// Two-read, one-write RV32 integer register file. Register 0 is hardwired
// to zero and has no storage. Optional build macro: REGFILE_BYPASS_EN
// (write-first forwarding on both read ports).
module reg_file
  import reg_file_pkg::*;
#(
  parameter int NUM_REGISTERS = NUM_REGISTERS_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int AW            = addr_width(NUM_REGISTERS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [AW-1:0]         ra1,
  input  logic [AW-1:0]         ra2,
  input  logic                  we,
  input  logic [AW-1:0]         wa,
  input  logic [DATA_WIDTH-1:0] wd,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2
);

  logic [NUM_REGISTERS-1:1][DATA_WIDTH-1:0] regs_q;
  logic [NUM_REGISTERS-1:1][DATA_WIDTH-1:0] regs_d;
  logic                                     wr_en;

  // Writes to register 0 are dropped; out-of-range addresses never match below.
  assign wr_en = we && (wa != AW'(ZERO_REG));

  // Next-state: only the addressed in-range entry takes the write data.
  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < NUM_REGISTERS; i++) begin
      if (wr_en && (wa == AW'(i))) regs_d[i] = wd;
    end
  end

  // Storage, cleared asynchronously so every entry is defined after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  regfile_read_port #(
    .NUM_REGISTERS (NUM_REGISTERS),
    .DATA_WIDTH    (DATA_WIDTH),
    .AW            (AW)
  ) u_rp1 (
    .regs_i   (regs_q),
    .ra_i     (ra1),
`ifdef REGFILE_BYPASS_EN
    .fwd_we_i (we && rst_n),
    .fwd_wa_i (wa),
    .fwd_wd_i (wd),
`endif
    .rd_o     (rd1)
  );

  regfile_read_port #(
    .NUM_REGISTERS (NUM_REGISTERS),
    .DATA_WIDTH    (DATA_WIDTH),
    .AW            (AW)
  ) u_rp2 (
    .regs_i   (regs_q),
    .ra_i     (ra2),
`ifdef REGFILE_BYPASS_EN
    .fwd_we_i (we && rst_n),
    .fwd_wa_i (wa),
    .fwd_wd_i (wd),
`endif
    .rd_o     (rd2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed, table-driven bench for reg_file (default 32 x 32 configuration).
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ra1, ra2, wa;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd1, rd2;

  int errors = 0;
  int checks = 0;

  reg_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (ra1),
    .ra2   (ra2),
    .we    (we),
    .wa    (wa),
    .wd    (wd),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_pre;

    // write (we, wa, wd) on one edge, then read (ra1, ra2) with we=0
    vecs[0] = '{1'b1, 5'd1,  32'hFFFF0000, 5'd1,  5'd1,  32'hFFFF0000, 32'hFFFF0000};
    vecs[1] = '{1'b1, 5'd0,  32'hFFFF0000, 5'd0,  5'd0,  32'h00000000, 32'h00000000};
    vecs[2] = '{1'b0, 5'd2,  32'hFFFF0001, 5'd2,  5'd2,  32'h00000000, 32'h00000000};
    vecs[3] = '{1'b1, 5'd31, 32'hDEADBEEF, 5'd31, 5'd1,  32'hDEADBEEF, 32'hFFFF0000};
    vecs[4] = '{1'b1, 5'd2,  32'hA5A5A5A5, 5'd2,  5'd31, 32'hA5A5A5A5, 32'hDEADBEEF};
    vecs[5] = '{1'b0, 5'd1,  32'h00000000, 5'd1,  5'd2,  32'hFFFF0000, 32'hA5A5A5A5};
    vecs[6] = '{1'b1, 5'd1,  32'h11111111, 5'd1,  5'd0,  32'h11111111, 32'h00000000};
    vecs[7] = '{1'b0, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd31, 32'h00000000, 32'hDEADBEEF};

    rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;

    // Writes attempted during reset must be ignored.
    @(negedge clk);
    we = 1'b1; wa = 5'd3; wd = 32'hCAFEF00D; ra1 = 5'd3; ra2 = 5'd3;
    @(posedge clk); #1;
    check("rst_write_ignored_rd1", rd1, 32'h0);
    @(negedge clk);
    we = 1'b0; rst_n = 1'b1; ra1 = 5'd0; ra2 = 5'd0;
    #1;
    check("reset_r0_rd1", rd1, 32'h0);
    check("reset_r0_rd2", rd2, 32'h0);
    ra1 = 5'd1; ra2 = 5'd1; #1;
    check("reset_r1_rd1", rd1, 32'h0);
    check("reset_r1_rd2", rd2, 32'h0);
    ra1 = 5'd3; #1;
    check("reset_r3_rd1", rd1, 32'h0);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
      @(posedge clk); #1;
      we = 1'b0; ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
      #1;
      check($sformatf("vec%0d_rd1", i), rd1, vecs[i].exp1);
      check($sformatf("vec%0d_rd2", i), rd2, vecs[i].exp2);
    end

    // Same-cycle write and read of register 5, then mid-cycle reset.
`ifdef REGFILE_BYPASS_EN
    exp_pre = 32'h12345678;
`else
    exp_pre = 32'h00000000;
`endif
    @(negedge clk);
    we = 1'b1; wa = 5'd5; wd = 32'h12345678; ra1 = 5'd5; ra2 = 5'd1;
    #1;
    check("same_cycle_pre_edge_rd1", rd1, exp_pre);
    @(posedge clk); #1;
    we = 1'b0;
    #1;
    check("same_cycle_post_edge_rd1", rd1, 32'h12345678);
    check("same_cycle_post_edge_rd2", rd2, 32'h11111111);
    rst_n = 1'b0;
    #1;
    check("async_reset_rd1", rd1, 32'h0);
    check("async_reset_rd2", rd2, 32'h0);

    // Release mid-cycle; first write lands on the first edge after release.
    @(negedge clk);
    rst_n = 1'b1; ra1 = 5'd31; ra2 = 5'd2;
    #1;
    check("post_reset_r31", rd1, 32'h0);
    check("post_reset_r2", rd2, 32'h0);
    we = 1'b1; wa = 5'd7; wd = 32'h0BADF00D; ra1 = 5'd7;
    @(posedge clk); #1;
    we = 1'b0;
    #1;
    check("first_write_after_reset", rd1, 32'h0BADF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
